// File: rtl/axi_drain_pkg.sv
// Shared types and default constants for the AXI drain/sleep controller.
// ctrl_of() gives the registered control outputs associated with each state.
package axi_drain_pkg;

  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_DRAIN_TIMEOUT   = 1024;
  localparam int DEF_WAKE_CYCLES     = 4;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ISOLATE = 3'd2,
    ST_SLEEP   = 3'd3,
    ST_WAKE    = 3'd4
  } state_t;

  typedef struct packed {
    logic block;
    logic iso;
    logic clk_en;
    logic ack;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '{block: 1'b0, iso: 1'b0, clk_en: 1'b1, ack: 1'b0};
    case (s)
      ST_DRAIN:   c = '{block: 1'b1, iso: 1'b0, clk_en: 1'b1, ack: 1'b0};
      ST_ISOLATE: c = '{block: 1'b1, iso: 1'b1, clk_en: 1'b1, ack: 1'b0};
      ST_SLEEP:   c = '{block: 1'b1, iso: 1'b1, clk_en: 1'b0, ack: 1'b1};
      ST_WAKE:    c = '{block: 1'b1, iso: 1'b1, clk_en: 1'b1, ack: 1'b0};
      default:    c = '{block: 1'b0, iso: 1'b0, clk_en: 1'b1, ack: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/axi_drain_cnt.sv
// Saturating up/down counter for outstanding AXI transactions.
// err flags an overflow (or optional underflow) attempt in the current cycle.
module axi_drain_cnt #(
  parameter int MAX       = 16,
  parameter int W         = $clog2(MAX + 1),
  parameter bit UNDER_ERR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         err
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic up;
  logic dn;

  // Simultaneous inc and dec cancel, so neither direction is taken.
  assign up = inc & ~dec & ~hold;
  assign dn = dec & ~inc & ~hold;

  always_comb begin
    err = 1'b0;
    if (up && count == MAX_V) err = 1'b1;
    if (UNDER_ERR && dn && count == '0) err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (up && count != MAX_V) begin
      count <= count + 1'b1;
    end else if (dn && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_drain_ctrl.sv
// Drains outstanding AXI traffic, isolates and clock-gates the downstream
// slice on a sleep request, and sequences the wake-up back to RUN.
module axi_drain_ctrl
  import axi_drain_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
  parameter int WAKE_CYCLES     = DEF_WAKE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sleep_req_i,
  output logic sleep_ack_o,
  input  logic incoming_req_i,
  output logic wake_o,
  output logic block_req_o,
  output logic isolate_o,
  output logic clk_en_o,
  input  logic aw_valid_i,
  input  logic aw_ready_i,
  input  logic ar_valid_i,
  input  logic ar_ready_i,
  input  logic w_valid_i,
  input  logic w_ready_i,
  input  logic w_last_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i,
  output logic timeout_o,
  output logic error_o,
  output state_t dbg_state,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_wr_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_rd_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_w_open
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  // A channel transfer happens in any cycle where valid and ready are both
  // high; valid/ready are only observed here, never driven.
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
  assign aw_hs     = aw_valid_i & aw_ready_i;
  assign ar_hs     = ar_valid_i & ar_ready_i;
  assign w_last_hs = w_valid_i & w_ready_i & w_last_i;
  assign b_hs      = b_valid_i & b_ready_i;
  assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

  state_t        state;
  ctrl_t         ctrl;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] wake_cnt;
  logic [CW-1:0] wr_out, rd_out, w_open;
  logic          wr_err, rd_err, wo_err;
  logic          cnt_clr, cnt_hold, idle;

  assign cnt_clr  = (state == ST_ISOLATE);
  assign cnt_hold = (state == ST_SLEEP) || (state == ST_WAKE);
  assign idle     = (wr_out == '0) && (rd_out == '0) && (w_open == '0) && !w_valid_i;

  axi_drain_cnt #(.MAX(MAX_OUTSTANDING), .W(CW), .UNDER_ERR(1'b1)) u_wr_cnt (
    .clk(clk_i), .rst(rst_i), .clr(cnt_clr), .hold(cnt_hold),
    .inc(aw_hs), .dec(b_hs), .count(wr_out), .err(wr_err)
  );

  axi_drain_cnt #(.MAX(MAX_OUTSTANDING), .W(CW), .UNDER_ERR(1'b1)) u_rd_cnt (
    .clk(clk_i), .rst(rst_i), .clr(cnt_clr), .hold(cnt_hold),
    .inc(ar_hs), .dec(r_last_hs), .count(rd_out), .err(rd_err)
  );

  // W data may legally precede its AW, so an early W-last is not an error.
  axi_drain_cnt #(.MAX(MAX_OUTSTANDING), .W(CW), .UNDER_ERR(1'b0)) u_w_cnt (
    .clk(clk_i), .rst(rst_i), .clr(cnt_clr), .hold(cnt_hold),
    .inc(aw_hs), .dec(w_last_hs), .count(w_open), .err(wo_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      ctrl      <= ctrl_of(ST_RUN);
      tmo_cnt   <= '0;
      wake_cnt  <= '0;
      wake_o    <= 1'b0;
      timeout_o <= 1'b0;
      error_o   <= 1'b0;
    end else begin
      error_o <= error_o | wr_err | rd_err | wo_err;
      wake_o  <= 1'b0;
      case (state)
        ST_RUN: begin
          if (sleep_req_i) begin
            state   <= ST_DRAIN;
            ctrl    <= ctrl_of(ST_DRAIN);
            tmo_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (!sleep_req_i) begin
            state <= ST_RUN;
            ctrl  <= ctrl_of(ST_RUN);
          end else if (idle) begin
            state <= ST_ISOLATE;
            ctrl  <= ctrl_of(ST_ISOLATE);
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= ST_ISOLATE;
            ctrl      <= ctrl_of(ST_ISOLATE);
            timeout_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_ISOLATE: begin
          state <= ST_SLEEP;
          ctrl  <= ctrl_of(ST_SLEEP);
        end
        ST_SLEEP: begin
          if (!sleep_req_i) begin
            state    <= ST_WAKE;
            ctrl     <= ctrl_of(ST_WAKE);
            wake_cnt <= '0;
          end else begin
            wake_o <= incoming_req_i;
          end
        end
        ST_WAKE: begin
          // sleep_req_i is deliberately not looked at until back in RUN.
          if (wake_cnt == WAKE_LAST) begin
            state <= ST_RUN;
            ctrl  <= ctrl_of(ST_RUN);
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          ctrl  <= ctrl_of(ST_RUN);
        end
      endcase
    end
  end

  assign block_req_o = ctrl.block;
  assign isolate_o   = ctrl.iso;
  assign clk_en_o    = ctrl.clk_en;
  assign sleep_ack_o = ctrl.ack;
  assign dbg_state   = state;
  assign dbg_wr_out  = wr_out;
  assign dbg_rd_out  = rd_out;
  assign dbg_w_open  = w_open;

endmodule

// File: tb/tb_axi_drain_ctrl.sv
// Directed bench for axi_drain_ctrl: drivers push expected observations,
// a negedge monitor pops and compares them against the DUT.
module tb_axi_drain_ctrl;
  import axi_drain_pkg::*;

  localparam int W = 25;
  localparam logic [6:0] O_RUN   = 7'b0010000;
  localparam logic [6:0] O_DRAIN = 7'b1010000;
  localparam logic [6:0] O_ISO   = 7'b1110000;
  localparam logic [6:0] O_SLEEP = 7'b1101000;
  localparam logic [6:0] O_WAKE  = 7'b1110000;
  localparam logic [6:0] B_WAKE  = 7'b0000100;
  localparam logic [6:0] B_TO    = 7'b0000010;
  localparam logic [6:0] B_ERR   = 7'b0000001;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic sleep_req_i = 1'b0, incoming_req_i = 1'b0;
  logic aw_valid_i = 1'b0, aw_ready_i = 1'b0, ar_valid_i = 1'b0, ar_ready_i = 1'b0;
  logic w_valid_i = 1'b0, w_ready_i = 1'b0, w_last_i = 1'b0;
  logic b_valid_i = 1'b0, b_ready_i = 1'b0;
  logic r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
  logic sleep_ack_o, wake_o, block_req_o, isolate_o, clk_en_o, timeout_o, error_o;
  state_t dbg_state;
  logic [4:0] dbg_wr_out, dbg_rd_out, dbg_w_open;

  axi_drain_ctrl #(.MAX_OUTSTANDING(16), .DRAIN_TIMEOUT(16), .WAKE_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .sleep_req_i(sleep_req_i), .sleep_ack_o(sleep_ack_o),
    .incoming_req_i(incoming_req_i), .wake_o(wake_o), .block_req_o(block_req_o),
    .isolate_o(isolate_o), .clk_en_o(clk_en_o),
    .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .ar_valid_i(ar_valid_i),
    .ar_ready_i(ar_ready_i), .w_valid_i(w_valid_i), .w_ready_i(w_ready_i),
    .w_last_i(w_last_i), .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .timeout_o(timeout_o), .error_o(error_o), .dbg_state(dbg_state),
    .dbg_wr_out(dbg_wr_out), .dbg_rd_out(dbg_rd_out), .dbg_w_open(dbg_w_open)
  );

  logic [W-1:0] obs;
  assign obs = {3'(dbg_state), block_req_o, isolate_o, clk_en_o, sleep_ack_o,
                wake_o, timeout_o, error_o, dbg_wr_out, dbg_rd_out, dbg_w_open};

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] ov(input state_t s, input logic [6:0] o,
                                      input int wr, input int rd, input int wo);
    return {3'(s), o, 5'(wr), 5'(rd), 5'(wo)};
  endfunction

  task automatic expect_obs(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", nm, obs, e);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hs(input logic aw, input logic w, input logic wl, input logic b,
                    input logic ar, input logic r, input logic rl);
    aw_valid_i = aw; aw_ready_i = aw;
    w_valid_i  = w;  w_ready_i  = w;  w_last_i = wl;
    b_valid_i  = b;  b_ready_i  = b;
    ar_valid_i = ar; ar_ready_i = ar;
    r_valid_i  = r;  r_ready_i  = r;  r_last_i = rl;
    step();
    {aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i} = '0;
    {b_valid_i, b_ready_i, ar_valid_i, ar_ready_i, r_valid_i, r_ready_i, r_last_i} = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc(2);
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    expect_obs("reset_state", ov(ST_RUN, O_RUN, 0, 0, 0));

    // drain completes only on the last B
    for (int i = 0; i < 3; i++) hs(1, 0, 0, 0, 0, 0, 0);
    expect_obs("three_aw", ov(ST_RUN, O_RUN, 3, 0, 3));
    hs(0, 1, 0, 0, 0, 0, 0);
    expect_obs("w_beat_no_last", ov(ST_RUN, O_RUN, 3, 0, 3));
    for (int i = 0; i < 3; i++) hs(0, 1, 1, 0, 0, 0, 0);
    expect_obs("three_w_bursts", ov(ST_RUN, O_RUN, 3, 0, 0));
    for (int i = 0; i < 2; i++) hs(0, 0, 0, 1, 0, 0, 0);
    expect_obs("two_b", ov(ST_RUN, O_RUN, 1, 0, 0));
    sleep_req_i = 1'b1;
    step();
    expect_obs("drain_entry", ov(ST_DRAIN, O_DRAIN, 1, 0, 0));
    cyc(3);
    expect_obs("drain_waits_b", ov(ST_DRAIN, O_DRAIN, 1, 0, 0));
    hs(0, 0, 0, 1, 0, 0, 0);
    expect_obs("last_b", ov(ST_DRAIN, O_DRAIN, 0, 0, 0));
    step();
    expect_obs("isolate", ov(ST_ISOLATE, O_ISO, 0, 0, 0));
    step();
    expect_obs("sleep", ov(ST_SLEEP, O_SLEEP, 0, 0, 0));

    // sleep holds counters, wake request, wake sequence
    hs(1, 0, 0, 0, 1, 0, 0);
    expect_obs("sleep_counters_frozen", ov(ST_SLEEP, O_SLEEP, 0, 0, 0));
    incoming_req_i = 1'b1;
    step();
    expect_obs("wake_req", ov(ST_SLEEP, O_SLEEP | B_WAKE, 0, 0, 0));
    incoming_req_i = 1'b0;
    sleep_req_i = 1'b0;
    step();
    expect_obs("wake_entry", ov(ST_WAKE, O_WAKE, 0, 0, 0));
    sleep_req_i = 1'b1;
    cyc(3);
    expect_obs("wake_ignores_sleep", ov(ST_WAKE, O_WAKE, 0, 0, 0));
    step();
    expect_obs("wake_to_run", ov(ST_RUN, O_RUN, 0, 0, 0));
    step();
    expect_obs("run_sees_sleep", ov(ST_DRAIN, O_DRAIN, 0, 0, 0));
    sleep_req_i = 1'b0;
    step();
    expect_obs("drain_abort", ov(ST_RUN, O_RUN, 0, 0, 0));

    // read counter with simultaneous inc/dec
    hs(0, 0, 0, 0, 1, 0, 0);
    hs(0, 0, 0, 0, 1, 0, 0);
    expect_obs("two_ar", ov(ST_RUN, O_RUN, 0, 2, 0));
    hs(0, 0, 0, 0, 1, 1, 1);
    expect_obs("ar_r_same_cycle", ov(ST_RUN, O_RUN, 0, 2, 0));
    hs(0, 0, 0, 0, 0, 1, 0);
    expect_obs("r_not_last", ov(ST_RUN, O_RUN, 0, 2, 0));
    hs(0, 0, 0, 0, 0, 1, 1);
    hs(0, 0, 0, 0, 0, 1, 1);
    expect_obs("r_last_x2", ov(ST_RUN, O_RUN, 0, 0, 0));

    // drain timeout with one read outstanding
    hs(0, 0, 0, 0, 1, 0, 0);
    sleep_req_i = 1'b1;
    step();
    expect_obs("tmo_drain_entry", ov(ST_DRAIN, O_DRAIN, 0, 1, 0));
    cyc(15);
    expect_obs("tmo_cycle15", ov(ST_DRAIN, O_DRAIN, 0, 1, 0));
    step();
    expect_obs("tmo_isolate", ov(ST_ISOLATE, O_ISO | B_TO, 0, 1, 0));
    step();
    expect_obs("tmo_sleep", ov(ST_SLEEP, O_SLEEP | B_TO, 0, 0, 0));
    sleep_req_i = 1'b0;
    cyc(5);
    expect_obs("tmo_back_run", ov(ST_RUN, O_RUN | B_TO, 0, 0, 0));

    // saturation and underflow
    do_reset();
    expect_obs("reset_clears_timeout", ov(ST_RUN, O_RUN, 0, 0, 0));
    for (int i = 0; i < 16; i++) hs(1, 0, 0, 0, 0, 0, 0);
    expect_obs("aw_16", ov(ST_RUN, O_RUN, 16, 0, 16));
    hs(1, 0, 0, 0, 0, 0, 0);
    expect_obs("aw_17_saturate", ov(ST_RUN, O_RUN | B_ERR, 16, 0, 16));
    do_reset();
    hs(0, 1, 1, 0, 0, 0, 0);
    expect_obs("w_before_aw", ov(ST_RUN, O_RUN, 0, 0, 0));
    hs(0, 0, 0, 1, 0, 0, 0);
    expect_obs("b_underflow", ov(ST_RUN, O_RUN | B_ERR, 0, 0, 0));

    // handshake in the cycle block rises is counted
    do_reset();
    sleep_req_i = 1'b1;
    hs(1, 1, 1, 0, 0, 0, 0);
    expect_obs("hs_at_block_rise", ov(ST_DRAIN, O_DRAIN, 1, 0, 0));
    sleep_req_i = 1'b0;
    step();
    hs(0, 0, 0, 1, 0, 0, 0);
    expect_obs("back_to_run", ov(ST_RUN, O_RUN, 0, 0, 0));

    // reset out of SLEEP
    sleep_req_i = 1'b1;
    cyc(3);
    expect_obs("sleep_again", ov(ST_SLEEP, O_SLEEP, 0, 0, 0));
    rst_i = 1'b1;
    step();
    expect_obs("reset_in_sleep", ov(ST_RUN, O_RUN, 0, 0, 0));
    rst_i = 1'b0;
    sleep_req_i = 1'b0;

    cyc(2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_drain_ctrl.md
AXI_DRAIN_CTRL -- requirements
Module: axi_drain_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, max outstanding reads and max outstanding writes each.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 1024, DRAIN cycles before forced isolation.
REQ-003 SHALL have parameter WAKE_CYCLES, default 4, clock-settle cycles in WAKE.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  sole clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 sleep_req_i  in  1  power manager requests downstream sleep.
REQ-008 sleep_ack_o  out  1  downstream drained, isolated, clock off.
REQ-009 incoming_req_i  in  1  slice holds a pending AW/AR.
REQ-010 wake_o  out  1  wake request to power manager.
REQ-011 block_req_o  out  1  blocks new AW/AR valids; W unaffected.
REQ-012 isolate_o  out  1  forces r_ready/b_ready high, masks valids downstream.
REQ-013 clk_en_o  out  1  downstream clock-gate enable.
REQ-014 aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i, w_valid_i, w_ready_i, w_last_i, b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i  in  1 each  monitored master-port handshakes.
REQ-015 timeout_o  out  1  sticky: drain timed out.
REQ-016 error_o  out  1  sticky: counter overflow/underflow.

Function
REQ-017 SHALL keep counters wr_out (+1 AW handshake, -1 B handshake), rd_out (+1 AR handshake, -1 R handshake with r_last_i), w_open (+1 AW handshake, -1 W handshake with w_last_i), width $clog2(MAX_OUTSTANDING+1).
REQ-018 Simultaneous increment and decrement on one counter SHALL leave it unchanged.
REQ-019 Increment at MAX_OUTSTANDING SHALL saturate and set error_o; decrement at 0 SHALL hold 0 and set error_o (w_open excepted: W-before-AW decrement at 0 holds 0, no error).
REQ-020 idle SHALL equal wr_out==0 & rd_out==0 & w_open==0 & ~w_valid_i.
REQ-021 FSM states RUN, DRAIN, ISOLATE, SLEEP, WAKE; all outputs registered.
REQ-022 RUN: block=0, iso=0, clk_en=1, ack=0; sleep_req_i -> DRAIN.
REQ-023 DRAIN: block=1, iso=0, clk_en=1; ~sleep_req_i -> RUN (priority); idle -> ISOLATE; timeout counter reaching DRAIN_TIMEOUT-1 -> ISOLATE and set timeout_o.
REQ-024 Handshakes in the cycle block_req_o rises SHALL still be counted.
REQ-025 ISOLATE: block=1, iso=1, clk_en=1, exactly one cycle, then SLEEP; wr_out, rd_out, w_open cleared on exit.
REQ-026 SLEEP: block=1, iso=1, clk_en=0, ack=1; wake_o = registered incoming_req_i; ~sleep_req_i -> WAKE.
REQ-027 WAKE: block=1, iso=1, clk_en=1, ack=0, wake_o=0; after WAKE_CYCLES cycles -> RUN.
REQ-028 sleep_req_i reasserted during WAKE SHALL be ignored until RUN.
REQ-029 Counters SHALL not change in SLEEP or WAKE.

Reset
REQ-030 rst_i SHALL force RUN, counters 0, block_req_o=0, isolate_o=0, clk_en_o=1, sleep_ack_o=0, wake_o=0, timeout_o=0, error_o=0, including mid-DRAIN or SLEEP.

Structure
REQ-031 State enum and default parameter constants SHALL live in shared package axi_drain_pkg.
REQ-032 One sub-module axi_drain_cnt (saturating up/down counter with error flag) SHALL be instantiated three times.

Verification
REQ-033 3 AWs, 3 W bursts, 2 Bs, sleep_req -> stays DRAIN; 3rd B -> ISOLATE 1 cycle, SLEEP, sleep_ack_o=1.
REQ-034 AR and R-last handshake same cycle with rd_out=2 -> rd_out stays 2.
REQ-035 1 read outstanding, no R for DRAIN_TIMEOUT=16 cycles -> ISOLATE on cycle 16, timeout_o=1, SLEEP reached.
REQ-036 In SLEEP incoming_req_i=1 -> wake_o=1 next cycle; drop sleep_req_i -> WAKE 4 cycles, RUN, clk_en_o=1.
REQ-037 17 AWs without B (MAX=16) -> wr_out=16, error_o=1; B with wr_out=0 -> error_o=1.
REQ-038 rst_i in SLEEP -> next cycle RUN, clk_en_o=1, isolate_o=0, sleep_ack_o=0.
